// File: rtl/lsu.sv
// RV32I load/store unit: one byte/half/word access per request over a req/ack data-memory port,
// with load formatting, misalignment, illegal-funct3 and timeout reporting.
module lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        busy,
   output logic        done,
   output logic [31:0] load_data,
   output logic [1:0]  err_code,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic [1:0]  state_o
);

   localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q;
   logic [1:0]      lane_q;
   logic [2:0]      f3_q;
   logic            write_q;
   logic [CW-1:0]   cnt_q;
   logic            busy_q, done_q, req_q, we_q;
   logic [31:0]     load_data_q, dmem_addr_q, dmem_wdata_q;
   logic [1:0]      err_q;
   logic [3:0]      dmem_be_q;

   logic            illegal, misaligned;
   logic [3:0]      be_d;
   logic [31:0]     wdata_d, rdata_fmt;
   logic [7:0]      rd_byte;
   logic [15:0]     rd_half;

   // Request decode works on the live inputs; only the accepted request gets latched.
   always_comb begin
      illegal    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (funct3[2] && mem_write);
      misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
      be_d    = 4'b1111;
      wdata_d = store_data;
      case (funct3[1:0])
         2'b00: begin
            be_d    = 4'b0001 << addr[1:0];
            wdata_d = {4{store_data[7:0]}};
         end
         2'b01: begin
            be_d    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{store_data[15:0]}};
         end
         default: ;
      endcase
   end

   // Load formatting uses the latched lane and funct3, not the (possibly changed) inputs.
   always_comb begin
      rd_byte   = dmem_rdata[8*lane_q +: 8];
      rd_half   = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      rdata_fmt = dmem_rdata;
      case (f3_q)
         3'b000:  rdata_fmt = {{24{rd_byte[7]}}, rd_byte};
         3'b100:  rdata_fmt = {24'd0, rd_byte};
         3'b001:  rdata_fmt = {{16{rd_half[15]}}, rd_half};
         3'b101:  rdata_fmt = {16'd0, rd_half};
         default: rdata_fmt = dmem_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         lane_q       <= 2'd0;
         f3_q         <= 3'd0;
         write_q      <= 1'b0;
         cnt_q        <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         req_q        <= 1'b0;
         we_q         <= 1'b0;
         load_data_q  <= 32'd0;
         err_q        <= 2'd0;
         dmem_addr_q  <= 32'd0;
         dmem_be_q    <= 4'd0;
         dmem_wdata_q <= 32'd0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  lane_q       <= addr[1:0];
                  f3_q         <= funct3;
                  write_q      <= mem_write;
                  cnt_q        <= '0;
                  load_data_q  <= 32'd0;
                  dmem_addr_q  <= {addr[31:2], 2'b00};
                  dmem_be_q    <= be_d;
                  dmem_wdata_q <= wdata_d;
                  if (illegal || misaligned) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     err_q   <= illegal ? 2'b10 : 2'b01;
                  end else begin
                     state_q <= S_REQ;
                     busy_q  <= 1'b1;
                     req_q   <= 1'b1;
                     we_q    <= mem_write;
                     err_q   <= 2'b00;
                  end
               end
            end
            S_REQ: begin
               // An ack in the last allowed cycle is checked first, so it beats the timeout.
               if (dmem_ack) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  req_q   <= 1'b0;
                  we_q    <= 1'b0;
                  err_q   <= 2'b00;
                  if (!write_q) load_data_q <= rdata_fmt;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                     state_q     <= S_DONE;
                     done_q      <= 1'b1;
                     busy_q      <= 1'b0;
                     req_q       <= 1'b0;
                     we_q        <= 1'b0;
                     err_q       <= 2'b11;
                     load_data_q <= 32'd0;
                  end
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign load_data  = load_data_q;
   assign err_code   = err_q;
   assign dmem_req   = req_q;
   assign dmem_we    = we_q;
   assign dmem_addr  = dmem_addr_q;
   assign dmem_be    = dmem_be_q;
   assign dmem_wdata = dmem_wdata_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed accesses from the test plan plus random accesses, checked
// against a behavioural model of the access rules and timing.
module tb_lsu;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        rst, start, mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr, store_data;
   logic        busy, done;
   logic [31:0] load_data;
   logic [1:0]  err_code;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic [1:0]  state_o;

   int errors = 0;
   int checks = 0;

   lsu #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst(rst), .start(start), .mem_write(mem_write), .funct3(funct3),
      .addr(addr), .store_data(store_data), .busy(busy), .done(done),
      .load_data(load_data), .err_code(err_code), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .state_o(state_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model of the access rules.
   function automatic logic [1:0] ref_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
      if (f3 == 3 || f3 == 6 || f3 == 7 || (we && f3 >= 4)) return 2'b10;
      if (((f3 == 1 || f3 == 5) && (a % 2 != 0)) || (f3 == 2 && (a % 4 != 0))) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
      int lane = int'(a % 4);
      if (f3 == 0 || f3 == 4) return 4'(1 << lane);
      if (f3 == 1 || f3 == 5) return 4'(3 << lane);
      return 4'hF;
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
      if (f3 == 0) return (sd & 32'hFF) * 32'h0101_0101;
      if (f3 == 1) return (sd & 32'hFFFF) * 32'h0001_0001;
      return sd;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] rd);
      int lane = int'(a % 4);
      logic [31:0] b, h;
      b = (rd >> (8 * lane)) & 32'hFF;
      h = (rd >> (16 * (lane / 2))) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
         3'd4:    return b;
         3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
         3'd5:    return h;
         default: return rd;
      endcase
   endfunction

   // One access: start in cycle 0, memory acks in REQ cycle ack_n (ack_n > T means never).
   task automatic access(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, input int ack_n,
                         input logic [31:0] rd, input bit start_in_done);
      logic [1:0]  e_exp, got_err;
      logic [31:0] got_ld;
      int n_req_exp, done_exp, reqs, busys, done_cyc, unstable;
      logic [31:0] ld_exp;
      e_exp = ref_err(we, f3, a);
      ld_exp = 32'd0;
      if (e_exp != 2'b00) begin
         n_req_exp = 0;
      end else if (ack_n <= T) begin
         n_req_exp = ack_n;
         if (!we) ld_exp = ref_load(f3, a, rd);
      end else begin
         n_req_exp = T;
         e_exp = 2'b11;
      end
      done_exp = n_req_exp + 1;

      @(negedge clk);
      start = 1'b1; mem_write = we; funct3 = f3; addr = a; store_data = sd;
      dmem_ack = 1'b0; dmem_rdata = rd;
      @(posedge clk);
      #1;
      start = 1'b0;
      addr = $urandom; store_data = $urandom; funct3 = 3'($urandom); mem_write = 1'($urandom);
      reqs = 0; busys = 0; done_cyc = -1; unstable = 0; got_err = 2'b00; got_ld = 32'd0;
      for (int c = 1; c <= T + 6 && done_cyc < 0; c++) begin
         @(negedge clk);
         if (busy) busys++;
         if (dmem_req) begin
            reqs++;
            if (reqs == 1) begin
               check({name, " addr"},  dmem_addr, a & 32'hFFFF_FFFC);
               check({name, " be"},    {28'd0, dmem_be}, {28'd0, ref_be(f3, a)});
               check({name, " we"},    {31'd0, dmem_we}, {31'd0, we});
               if (we) check({name, " wdata"}, dmem_wdata, ref_wdata(f3, sd));
            end else if (dmem_addr !== (a & 32'hFFFF_FFFC) || dmem_be !== ref_be(f3, a) ||
                         dmem_we !== we) begin
               unstable++;
            end
         end
         if (done) begin
            done_cyc = c;
            got_err = err_code;
            got_ld = load_data;
         end
         dmem_ack = dmem_req && (reqs == ack_n);
      end
      dmem_ack = 1'b0;
      check({name, " done_cycle"}, done_cyc, done_exp);
      check({name, " err"},        {30'd0, got_err}, {30'd0, e_exp});
      check({name, " req_cycles"}, reqs, n_req_exp);
      check({name, " busy_cycles"}, busys, n_req_exp);
      if (n_req_exp > 1) check({name, " req_unstable"}, unstable, 0);
      if (!we || e_exp != 2'b00) check({name, " load_data"}, got_ld, ld_exp);
      if (start_in_done && done_cyc > 0) begin
         start = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h40;
         @(posedge clk);
         #1;
         start = 1'b0;
         @(negedge clk);
         check({name, " start_in_done_ignored"}, {30'd0, busy, dmem_req}, 32'd0);
      end
   endtask

   initial begin
      logic [2:0] f3_tab [8];
      f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
      rst = 1'b1; start = 1'b0; mem_write = 1'b0; funct3 = 3'd0; addr = 32'd0;
      store_data = 32'd0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
      #1;
      check("reset ctrl", {28'd0, busy, done, dmem_req, dmem_we}, 32'd0);
      check("reset load_data", load_data, 32'd0);
      check("reset err", {30'd0, err_code}, 32'd0);
      check("reset dmem_addr", dmem_addr, 32'd0);
      check("reset be_wdata", dmem_wdata | {28'd0, dmem_be}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      access("sw",  1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 1, 32'd0, 1'b0);
      access("lb",  1'b0, 3'b000, 32'h103, 32'd0, 1, 32'h80FF_1234, 1'b0);
      access("lbu", 1'b0, 3'b100, 32'h103, 32'd0, 1, 32'h80FF_1234, 1'b0);
      access("lh",  1'b0, 3'b001, 32'h102, 32'd0, 3, 32'h8001_0000, 1'b1);
      access("lw_mis", 1'b0, 3'b010, 32'h101, 32'd0, 1, 32'd0, 1'b0);
      access("sbu", 1'b1, 3'b100, 32'h100, 32'h12, 1, 32'd0, 1'b1);
      access("timeout", 1'b0, 3'b010, 32'h200, 32'd0, T + 1, 32'h1234_5678, 1'b0);
      access("ack_last", 1'b0, 3'b010, 32'h204, 32'd0, T, 32'hCAFE_F00D, 1'b0);

      // Reset during the second REQ cycle must drop the request at once.
      @(negedge clk);
      start = 1'b1; mem_write = 1'b1; funct3 = 3'b010; addr = 32'h300; store_data = 32'h1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_mid pre_req", {31'd0, dmem_req}, 32'd1);
      #1;
      rst = 1'b1;
      #1;
      check("rst_mid async_drop", {29'd0, dmem_req, busy, done}, 32'd0);
      @(negedge clk);
      check("rst_mid no_done", {31'd0, done}, 32'd0);
      rst = 1'b0;
      access("sb_after_rst", 1'b1, 3'b000, 32'h002, 32'h55, 1, 32'd0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         logic [31:0] a;
         logic [2:0]  f3;
         a = $urandom;
         f3 = f3_tab[$urandom_range(0, 7)];
         access("rand", 1'($urandom), f3, a, $urandom, $urandom_range(1, T + 1), $urandom,
                1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the ALU in the rv32i_sc datapath. It takes the ALU result as the effective address, performs one RV32I load or store per request against a single-port data memory using a req/ack handshake, and returns sign- or zero-extended load data. It stalls the core via `busy` while the access is outstanding, and it reports misalignment, illegal funct3 and memory timeout.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum number of consecutive REQ cycles without `dmem_ack` before the access is aborted. Must be ≥1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request pulse from the core. Sampled only in IDLE; ignored in every other state.
- `mem_write`  in  1  1 = store, 0 = load. Sampled with `start`.
- `funct3`  in  3  000 B, 001 H, 010 W, 100 BU (load only), 101 HU (load only).
- `addr`  in  32  effective address, taken from the ALU `results` output.
- `store_data`  in  32  rs2 value.
- `busy`  out  1  high in REQ.
- `done`  out  1  one-cycle pulse in DONE.
- `load_data`  out  32  formatted load result. Valid from `done` until the next accepted `start`.
- `err_code`  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout. Valid with `done`.
- `dmem_req`  out  1  high only in REQ.
- `dmem_we`  out  1  `dmem_req` AND latched `mem_write`.
- `dmem_addr`  out  32  latched `addr` with bits [1:0] forced to 00.
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  32  replicated store data.
- `dmem_ack`  in  1  memory completion. Sampled only in REQ.
- `dmem_rdata`  in  32  read word. Valid in the cycle `dmem_ack` is high.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE + `start`:
  - Latch `addr`, `funct3`, `mem_write` and `store_data`.
  - Illegal funct3 (011, 110, 111, or 100/101 with `mem_write`=1) → DONE with err 10.
  - Else misaligned (H with `addr[0]`=1, W with `addr[1:0]`≠00) → DONE with err 01.
  - Illegal funct3 has priority over misalignment.
  - Else → REQ, timeout counter cleared to 0.
  - On an error path no memory request is issued and `load_data` = 0.
- REQ:
  - `dmem_ack`=1 → DONE, err 00. For loads, capture the formatted `dmem_rdata` into `load_data`.
  - Else counter +1. When the count reaches `TIMEOUT_CYCLES` (i.e. `TIMEOUT_CYCLES` ack-less REQ cycles) → DONE, err 11, `load_data` = 0.
  - An ack in the final allowed cycle wins over timeout.
- DONE → IDLE unconditionally. A `start` in DONE is ignored.
- Byte enables:
  - B: `4'b0001 << addr[1:0]`.
  - H: `addr[1]` ? 1100 : 0011.
  - W: 1111.
  - Driven for loads as well as stores.
- Store data: B → `{4{store_data[7:0]}}`; H → `{2{store_data[15:0]}}`; W → `store_data`.
- Load format: select the byte at lane `addr[1:0]` or the half at `addr[1]`, then sign-extend (B, H) or zero-extend (BU, HU). W passes through.
- `dmem_addr`, `dmem_be` and `dmem_wdata` are registered and stay stable for the whole of REQ.

## Timing
- Reset values:
  - State = IDLE.
  - `busy`, `done`, `dmem_req`, `dmem_we` = 0.
  - `load_data`, `err_code`, `dmem_addr`, `dmem_be`, `dmem_wdata` and the counter = 0.
  - Reset mid-REQ drops `dmem_req` immediately and asynchronously, with no completion reported.
- Valid access with `start` at cycle 0 and ack in the n-th REQ cycle (n≥1): REQ spans cycles 1..n, `done` is in cycle n+1. The minimum latency is 2 cycles.
- Error (misaligned or illegal): `done` in cycle 1, `busy` never asserted.
- Timeout: REQ spans cycles 1..`TIMEOUT_CYCLES`, `done` with err 11 in cycle `TIMEOUT_CYCLES`+1.
- Back-to-back accesses: the next `start` is accepted earliest in the cycle after `done`.

## Test plan
- SW: addr 0x100, data 0xDEADBEEF, ack in the 1st REQ cycle → `dmem_addr` 0x100, be 1111, wdata 0xDEADBEEF, `dmem_we`=1, `done` at cycle 2, err 00.
- LB and LBU: addr 0x103, rdata 0x80FF_1234 → LB gives 0xFFFFFF80, LBU gives 0x00000080, be 1000.
- LH: addr 0x102, rdata 0x8001_0000, ack after 3 REQ cycles → `load_data` 0xFFFF8001, `busy` high for 3 cycles, `done` at cycle 4.
- Misaligned LW at 0x101 → `done` at cycle 1, err 01, `dmem_req` never high. SBU (funct3 100 with store) → err 10.
- Timeout with `TIMEOUT_CYCLES`=4, no ack → err 11 at cycle 5. Repeat with ack in the 4th REQ cycle → err 00.
- Assert `rst` in the 2nd REQ cycle → `dmem_req` and `busy` fall within the same cycle, no `done`. After release, a new SB at 0x002 with data 0x55 gives be 0100 and wdata 0x55555555.
